// File: rtl/cpu_mem_pkg.sv
// ---------------------------------------------------------------------------
// cpu_mem_pkg
// Shared types and constants for the CPU memory responder.
//   state_t     : responder operating phase (loading, running, halted)
//   region_t    : result of decoding a bus address against the memory map
//   decode_addr : classifies an address as ROM, RAM or unmapped
// ---------------------------------------------------------------------------
package cpu_mem_pkg;

  // Default memory map. ROM runs from 0 up to ROM_END_ADDR and RAM starts
  // right after it.
  localparam int unsigned RAM_BASE_ADDR  = 32'h1800;
  localparam int unsigned ROM_END_ADDR   = RAM_BASE_ADDR - 1;
  localparam int unsigned RAM_DEPTH_DEF  = 256;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    REG_ROM      = 2'd0,
    REG_RAM      = 2'd1,
    REG_UNMAPPED = 2'd2
  } region_t;

  // Everything below base is ROM, the next depth bytes are RAM, and the
  // remainder of the address space is unmapped.
  function automatic region_t decode_addr(input int unsigned a,
                                          input int unsigned base,
                                          input int unsigned depth);
    if (a < base)
      return REG_ROM;
    else if (a < base + depth)
      return REG_RAM;
    else
      return REG_UNMAPPED;
  endfunction

endpackage

// File: rtl/mem_sp_sync.sv
// ---------------------------------------------------------------------------
// mem_sp_sync
// Single-port synchronous byte array with a registered read. The array is
// never cleared; only the read register is loaded, and only when re is high,
// so the last read value is held between reads.
//   clk   : clock, rising edge
//   addr  : shared read/write index
//   we    : write enable, stores wdata at addr
//   wdata : write data
//   re    : read enable, captures mem[addr] into rdata
//   rdata : registered read data
// ---------------------------------------------------------------------------
module mem_sp_sync #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8,
  parameter int unsigned DW    = 8
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Storage and read register. No reset here on purpose: memory contents
  // must survive a reset so a program can be restarted without reloading.
  always_ff @(posedge clk) begin
    if (we)
      mem[addr] <= wdata;
    if (re)
      rdata <= mem[addr];
  end

endmodule

// File: rtl/cpu_mem_resp.sv
// ---------------------------------------------------------------------------
// cpu_mem_resp
// Memory-side responder for the 8-bit RISC core. Holds program ROM and a
// data RAM window, is filled by a loader before execution, answers CPU
// reads (1-cycle latency) and edge-qualified writes, and keeps sticky error
// flags plus saturating access counters.
//   sys_clk, rst_n          : clock, synchronous active-low reset
//   addr, rd, wr, wdata     : CPU bus request
//   halt                    : CPU halt indication
//   rdata, data_oe          : read data and bus drive enable
//   ld_valid/ready/addr/data: loader byte handshake
//   ld_done                 : ends loading, starts RUN
//   run, halted             : current phase
//   wr_err, map_err, proto_err : sticky error flags
//   rd_cnt, wr_cnt          : saturating accepted-access counters
// ---------------------------------------------------------------------------
module cpu_mem_resp
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W    = 13,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned RAM_BASE  = RAM_BASE_ADDR,
  parameter int unsigned RAM_DEPTH = RAM_DEPTH_DEF,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rd,
  input  logic              wr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              halt,
  output logic [DATA_W-1:0] rdata,
  output logic              data_oe,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_done,
  output logic              run,
  output logic              halted,
  output logic              wr_err,
  output logic              map_err,
  output logic              proto_err,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  wr_cnt
);

  localparam int unsigned ROM_AW = $clog2(RAM_BASE);
  localparam int unsigned RAM_AW = $clog2(RAM_DEPTH);

  state_t              state_q, state_d;
  region_t             cpu_region, ld_region, rd_sel_q;
  logic                in_load, in_run;
  logic                wr_q;
  logic                rd_acc, wr_acc, proto_hit;
  logic [ROM_AW-1:0]   rom_addr;
  logic [RAM_AW-1:0]   ram_addr;
  logic                rom_we, ram_we, rom_re, ram_re;
  logic [DATA_W-1:0]   mem_wdata, rom_rdata, ram_rdata;

  // Address decode for both requesters and the qualified CPU accesses.
  // A write only happens on the rising edge of wr, so a long strobe is one
  // write. rd and wr together cancel both accesses.
  assign cpu_region = decode_addr(32'(addr), RAM_BASE, RAM_DEPTH);
  assign ld_region  = decode_addr(32'(ld_addr), RAM_BASE, RAM_DEPTH);
  assign in_load    = (state_q == ST_LOAD);
  assign in_run     = (state_q == ST_RUN);
  assign ld_ready   = ld_valid & in_load & ~ld_done;
  assign rd_acc     = in_run & rd & ~wr;
  assign wr_acc     = in_run & wr & ~wr_q & ~rd;
  assign proto_hit  = in_run & rd & wr;
  assign run        = in_run;
  assign halted     = (state_q == ST_HALTED);

  // Each memory has a single port, shared between the loader (LOAD) and the
  // CPU (RUN). RAM is indexed by the offset from its base address.
  assign rom_addr  = in_load ? ROM_AW'(ld_addr) : ROM_AW'(addr);
  assign ram_addr  = in_load ? RAM_AW'(ld_addr - ADDR_W'(RAM_BASE))
                             : RAM_AW'(addr - ADDR_W'(RAM_BASE));
  assign mem_wdata = in_load ? ld_data : wdata;
  assign rom_we    = ld_ready & (ld_region == REG_ROM);
  assign ram_we    = (ld_ready & (ld_region == REG_RAM)) |
                     (wr_acc & (cpu_region == REG_RAM));
  assign rom_re    = rd_acc & (cpu_region == REG_ROM);
  assign ram_re    = rd_acc & (cpu_region == REG_RAM);

  mem_sp_sync #(.DEPTH(RAM_BASE), .AW(ROM_AW), .DW(DATA_W)) u_rom (
    .clk   (sys_clk),
    .addr  (rom_addr),
    .we    (rom_we),
    .wdata (mem_wdata),
    .re    (rom_re),
    .rdata (rom_rdata)
  );

  mem_sp_sync #(.DEPTH(RAM_DEPTH), .AW(RAM_AW), .DW(DATA_W)) u_ram (
    .clk   (sys_clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (mem_wdata),
    .re    (ram_re),
    .rdata (ram_rdata)
  );

  // Phase sequencing: LOAD until the loader finishes, RUN until the core
  // halts, then HALTED until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD:   if (ld_done) state_d = ST_RUN;
      ST_RUN:    if (halt)    state_d = ST_HALTED;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_LOAD;
    endcase
  end

  // Read data comes from whichever array served the most recent read.
  // Unmapped reads and the reset state select zero; both memory read
  // registers hold between reads, so rdata holds too.
  always_comb begin
    rdata = '0;
    case (rd_sel_q)
      REG_ROM: rdata = rom_rdata;
      REG_RAM: rdata = ram_rdata;
      default: rdata = '0;
    endcase
  end

  // State, bus-drive, error and counter registers. A halt in the same cycle
  // as a read still lets the read complete, because data_oe and the read
  // select are registered from the RUN-cycle request.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q   <= ST_LOAD;
      wr_q      <= 1'b0;
      data_oe   <= 1'b0;
      rd_sel_q  <= REG_UNMAPPED;
      wr_err    <= 1'b0;
      map_err   <= 1'b0;
      proto_err <= 1'b0;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr;
      data_oe <= rd_acc;
      if (rd_acc)
        rd_sel_q <= cpu_region;
      if (rd_acc && (cpu_region == REG_UNMAPPED))
        map_err <= 1'b1;
      if (wr_acc && (cpu_region != REG_RAM))
        wr_err <= 1'b1;
      if (proto_hit)
        proto_err <= 1'b1;
      if (rd_acc && (rd_cnt != '1))
        rd_cnt <= rd_cnt + CNT_W'(1);
      if (wr_acc && (wr_cnt != '1))
        wr_cnt <= wr_cnt + CNT_W'(1);
    end
  end

endmodule
